// File: rtl/latch_seq_pkg.sv
// latch_seq_pkg: shared state encoding and counter sizing for the latch phase sequencer.
package latch_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      M_OPEN = 3'd1,
      GAP1   = 3'd2,
      S_OPEN = 3'd3,
      GAP2   = 3'd4
   } state_t;

   function automatic int cnt_w(input int open_cyc, input int gap_cyc);
      return $clog2(((open_cyc > gap_cyc) ? open_cyc : gap_cyc) + 1);
   endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter with zero flag; saturates at zero.
module phase_timer #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] cnt,
   output logic          zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - CW'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/latch_phase_sequencer.sv
// latch_phase_sequencer: non-overlapping master/slave latch enables with req/ack load handshake.
// Optional slave readback check enabled by LATCH_SEQ_READBACK_EN (adds q_rb / rb_err).
module latch_phase_sequencer
   import latch_seq_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int OPEN_CYC = 2,
   parameter int GAP_CYC  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_req,
   input  logic [WIDTH-1:0] load_data,
`ifdef LATCH_SEQ_READBACK_EN
   input  logic [WIDTH-1:0] q_rb,
   output logic             rb_err,
`endif
   output logic             busy,
   output logic             load_ack,
   output logic             m_en,
   output logic             s_en,
   output logic [WIDTH-1:0] m_d
);

   localparam int CW = cnt_w(OPEN_CYC, GAP_CYC);
   localparam logic [CW-1:0] OPEN_LD = CW'(OPEN_CYC - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

   generate
      if (OPEN_CYC < 1 || GAP_CYC < 1) begin : g_param_chk
         $error("latch_phase_sequencer: OPEN_CYC and GAP_CYC must both be >= 1");
      end
   endgenerate

   state_t          state, state_nxt;
   logic            accept;
   logic            tmr_load;
   logic [CW-1:0]   tmr_val;
   logic [CW-1:0]   cnt;
   logic            zero;

   phase_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .cnt      (cnt),
      .zero     (zero)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = load_req ? M_OPEN : IDLE;
         M_OPEN:  state_nxt = zero ? GAP1 : M_OPEN;
         GAP1:    state_nxt = zero ? S_OPEN : GAP1;
         S_OPEN:  state_nxt = zero ? GAP2 : S_OPEN;
         GAP2:    state_nxt = zero ? IDLE : GAP2;
         default: state_nxt = IDLE;
      endcase
      accept   = (state == IDLE) && load_req;
      // Every phase change reloads the timer with the new phase length minus one
      tmr_load = (state_nxt != state);
      tmr_val  = (state_nxt == M_OPEN || state_nxt == S_OPEN) ? OPEN_LD :
                 (state_nxt == GAP1   || state_nxt == GAP2)   ? GAP_LD  : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         load_ack <= 1'b0;
         m_en     <= 1'b0;
         s_en     <= 1'b0;
         m_d      <= '0;
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt != IDLE);
         load_ack <= (state == GAP2) && (state_nxt == IDLE);
         m_en     <= (state_nxt == M_OPEN);
         s_en     <= (state_nxt == S_OPEN);
         if (accept) m_d <= load_data;
      end
   end

`ifdef LATCH_SEQ_READBACK_EN
   // The timer still holds its reload value only during the first GAP2 cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rb_err <= 1'b0;
      else if (accept) rb_err <= 1'b0;
      else if (state == GAP2 && cnt == GAP_LD && q_rb != m_d) rb_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_latch_phase_sequencer.sv
// tb_latch_phase_sequencer: directed checks of enable timing, handshake, reset and readback.
module tb_latch_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_req, req2;
   logic [7:0] load_data, data2;
   logic       busy, load_ack, m_en, s_en;
   logic       busy2, ack2, m_en2, s_en2;
   logic [7:0] m_d, m_d2;
`ifdef LATCH_SEQ_READBACK_EN
   logic [7:0] q_rb;
   logic       rb_err, rb_err2;
`endif

   int total = 0;
   int bad = 0;
   int acks;

   always #5 clk = ~clk;

   latch_phase_sequencer u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_req  (load_req),
      .load_data (load_data),
`ifdef LATCH_SEQ_READBACK_EN
      .q_rb      (q_rb),
      .rb_err    (rb_err),
`endif
      .busy      (busy),
      .load_ack  (load_ack),
      .m_en      (m_en),
      .s_en      (s_en),
      .m_d       (m_d)
   );

   latch_phase_sequencer #(.WIDTH(8), .OPEN_CYC(3), .GAP_CYC(2)) u_dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_req  (req2),
      .load_data (data2),
`ifdef LATCH_SEQ_READBACK_EN
      .q_rb      (m_d2),
      .rb_err    (rb_err2),
`endif
      .busy      (busy2),
      .load_ack  (ack2),
      .m_en      (m_en2),
      .s_en      (s_en2),
      .m_d       (m_d2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cyc(input int k, input logic em, input logic es, input logic ea, input logic eb);
      chk($sformatf("m_en@%0d", k), m_en, em);
      chk($sformatf("s_en@%0d", k), s_en, es);
      chk($sformatf("ack@%0d", k), load_ack, ea);
      chk($sformatf("busy@%0d", k), busy, eb);
      chk($sformatf("overlap@%0d", k), m_en && s_en, 1'b0);
   endtask

   task automatic cyc2(input int k, input logic em, input logic es, input logic ea, input logic eb);
      chk($sformatf("m_en2@%0d", k), m_en2, em);
      chk($sformatf("s_en2@%0d", k), s_en2, es);
      chk($sformatf("ack2@%0d", k), ack2, ea);
      chk($sformatf("busy2@%0d", k), busy2, eb);
      chk($sformatf("overlap2@%0d", k), m_en2 && s_en2, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; load_req = 1'b0; load_data = 8'h00; req2 = 1'b0; data2 = 8'h00;
`ifdef LATCH_SEQ_READBACK_EN
      q_rb = 8'h00;
`endif
      repeat (2) @(negedge clk);
      chk("rst_m_en", m_en, 1'b0);
      chk("rst_s_en", s_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ack", load_ack, 1'b0);
      chk("rst_m_d", m_d, 8'h00);
      rst_n = 1'b1;
      step();

      // single load of A5: m_en 1-2, gap 3, s_en 4-5, gap 6, ack 7
      load_req = 1'b1; load_data = 8'hA5;
      step();
      load_req = 1'b0; load_data = 8'h00;
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) step();
         cyc(k, k == 1 || k == 2, k == 4 || k == 5, k == 7, k <= 6);
         chk($sformatf("t1_m_d@%0d", k), m_d, 8'hA5);
      end
      step();
      chk("t1_idle_ack", load_ack, 1'b0);
      chk("t1_idle_busy", busy, 1'b0);
      chk("t1_idle_m_d", m_d, 8'hA5);

      // back-to-back loads with load_req held
      load_req = 1'b1; load_data = 8'h01;
      step();
      load_data = 8'h02;
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) step();
         cyc(k, k == 1 || k == 2, k == 4 || k == 5, k == 7, k <= 6);
         chk($sformatf("t2a_m_d@%0d", k), m_d, 8'h01);
      end
      step();
      load_req = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) step();
         cyc(k, k == 1 || k == 2, k == 4 || k == 5, k == 7, k <= 6);
         chk($sformatf("t2b_m_d@%0d", k), m_d, 8'h02);
      end
      step();
      chk("t2_idle_busy", busy, 1'b0);

      // request during S_OPEN is ignored
      load_req = 1'b1; load_data = 8'h11;
      step();
      load_req = 1'b0;
      repeat (3) step();
      chk("t3_s_open", s_en, 1'b1);
      load_req = 1'b1; load_data = 8'h3C;
      step();
      load_req = 1'b0;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         acks += int'(load_ack);
         chk($sformatf("t3_m_d@%0d", i), m_d, 8'h11);
         step();
      end
      chk("t3_ack_count", acks, 1);
      chk("t3_busy_end", busy, 1'b0);

      // async reset mid M_OPEN
      load_req = 1'b1; load_data = 8'h77;
      step();
      load_req = 1'b0;
      chk("t4_m_en_pre", m_en, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_m_en_rst", m_en, 1'b0);
      chk("t4_s_en_rst", s_en, 1'b0);
      chk("t4_busy_rst", busy, 1'b0);
      chk("t4_m_d_rst", m_d, 8'h00);
      chk("t4_ack_rst", load_ack, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         acks += int'(load_ack);
      end
      chk("t4_no_ack", acks, 0);
      chk("t4_busy_after", busy, 1'b0);
      load_req = 1'b1; load_data = 8'hFF;
      step();
      load_req = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         if (k > 1) step();
         cyc(k, k == 1 || k == 2, k == 4 || k == 5, k == 7, k <= 6);
         chk($sformatf("t4_m_d@%0d", k), m_d, 8'hFF);
      end
      step();

      // OPEN_CYC=3, GAP_CYC=2: m_en 1-3, gap 4-5, s_en 6-8, gap 9-10, ack 11
      req2 = 1'b1; data2 = 8'hC3;
      step();
      req2 = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         if (k > 1) step();
         cyc2(k, k >= 1 && k <= 3, k >= 6 && k <= 8, k == 11, k <= 10);
         chk($sformatf("t5_m_d@%0d", k), m_d2, 8'hC3);
      end
      step();
      chk("t5_idle_busy", busy2, 1'b0);

`ifdef LATCH_SEQ_READBACK_EN
      q_rb = 8'h5B;
      load_req = 1'b1; load_data = 8'h5A;
      step();
      load_req = 1'b0;
      repeat (6) step();
      chk("rb_ack", load_ack, 1'b1);
      chk("rb_err_set", rb_err, 1'b1);
      step();
      chk("rb_err_sticky", rb_err, 1'b1);
      q_rb = 8'h66;
      load_req = 1'b1; load_data = 8'h66;
      step();
      load_req = 1'b0;
      chk("rb_err_clear", rb_err, 1'b0);
      repeat (6) step();
      chk("rb_ack2", load_ack, 1'b1);
      chk("rb_err_match", rb_err, 1'b0);
      chk("rb_err2", rb_err2, 1'b0);
      step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
